// File: rtl/fcn_matrix_mult_transpose.sv
// Transpose matrix-vector unit for the FC backward pass: out_vec = W^T * grad_vec.
// One weight row is consumed per ACCUM cycle, with N parallel MACs into wrapping accumulators.
module fcn_matrix_mult_transpose #(
    parameter int M          = 4,
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] grad_vec [M],
    input  logic signed [DATA_WIDTH-1:0] weight [M][N],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  out_vec [N],
    output logic                         busy,
    output logic [1:0]                   state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds data while valid && !ready; ready never depends on valid.
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]   grad_q [M];
    logic signed [DATA_WIDTH-1:0]   grad_d [M];
    logic signed [ACC_WIDTH-1:0]    acc_q [N];
    logic signed [ACC_WIDTH-1:0]    acc_d [N];
    logic signed [2*DATA_WIDTH-1:0] prod [N];

    // Full-width products of the current grad element against row idx.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            prod[n] = grad_q[idx_q] * weight[idx_q][n];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grad_d  = grad_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    grad_d  = grad_vec;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                    for (int n = 0; n < N; n++) begin
                        acc_d[n] = '0;
                    end
                end
            end
            S_ACCUM: begin
                // Size cast sign-extends or truncates the product; the sum wraps.
                for (int n = 0; n < N; n++) begin
                    acc_d[n] = acc_q[n] + ACC_WIDTH'(prod[n]);
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            for (int m = 0; m < M; m++) begin
                grad_q[m] <= '0;
            end
            for (int n = 0; n < N; n++) begin
                acc_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grad_q  <= grad_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign state_o   = state_q;
    assign out_vec   = acc_q;

endmodule

// File: tb/tb_fcn_matrix_mult_transpose.sv
// Directed bench for fcn_matrix_mult_transpose: latency, transpose indexing, signed wrap,
// backpressure, mid-operation reset and back-to-back streaming, all against hand-computed values.
module tb_fcn_matrix_mult_transpose;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 32;

    typedef logic signed [DW-1:0] gvec_t [M];
    typedef logic signed [AW-1:0] ovec_t [N];

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [DW-1:0] grad_vec [M];
    logic signed [DW-1:0] weight [M][N];
    logic              out_valid;
    logic              out_ready;
    logic signed [AW-1:0] out_vec [N];
    logic              busy;
    logic [1:0]        state_o;

    int checks = 0;
    int errors = 0;

    fcn_matrix_mult_transpose #(
        .M(M), .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .grad_vec(grad_vec),
        .weight(weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec(out_vec),
        .busy(busy),
        .state_o(state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic set_identity();
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                weight[m][n] = (m == n) ? 16'sd1 : 16'sd0;
    endtask

    task automatic set_weight_ramp();
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                weight[m][n] = DW'(4 * m + n);
    endtask

    task automatic set_weight_const(input logic signed [DW-1:0] v);
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                weight[m][n] = v;
    endtask

    // Called at a negedge; returns at the negedge where out_valid is first seen high.
    // lat counts cycles from the accept cycle to the first out_valid cycle.
    task automatic run_txn(input gvec_t g, output ovec_t res, output int lat, output bit ok);
        int n;
        ok       = 1'b1;
        lat      = 0;
        grad_vec = g;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            ok       = 1'b0;
            in_valid = 1'b0;
            res      = out_vec;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < M; i++) grad_vec[i] = DW'($urandom_range(0, 65535));
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        res = out_vec;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < M; i++) grad_vec[i] = '0;
        set_identity();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
        for (int n = 0; n < N; n++) begin
            checks++;
            if (out_vec[n] !== 32'sd0) begin
                errors++;
                $display("FAIL reset_out_vec[%0d]: got %0d, required 0", n, out_vec[n]);
            end
        end
    endtask

    task automatic test_identity();
        gvec_t g = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        ovec_t e = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
        ovec_t r;
        int    lat;
        bit    ok;
        set_identity();
        out_ready = 1'b1;
        run_txn(g, r, lat, ok);
        checks++;
        if (!ok || lat != 5) begin
            errors++;
            $display("FAIL identity_latency: ok=%0d latency=%0d, required ok=1 latency=5", ok, lat);
        end
        for (int n = 0; n < N; n++) begin
            checks++;
            if (r[n] !== e[n]) begin
                errors++;
                $display("FAIL identity_out[%0d]: got %0d, required %0d", n, r[n], e[n]);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL identity_valid_pulse: out_valid=%b in_ready=%b, required 0 1",
                     out_valid, in_ready);
        end
        checks++;
        if (out_vec[3] !== 32'sd4) begin
            errors++;
            $display("FAIL identity_hold_after_consume: got %0d, required 4", out_vec[3]);
        end
    endtask

    task automatic test_transpose();
        gvec_t g1 = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        gvec_t g2 = '{16'sd0, 16'sd0, 16'sd0, 16'sd2};
        ovec_t e1 = '{32'sd24, 32'sd28, 32'sd32, 32'sd36};
        ovec_t e2 = '{32'sd24, 32'sd26, 32'sd28, 32'sd30};
        ovec_t r;
        int    lat;
        bit    ok;
        set_weight_ramp();
        run_txn(g1, r, lat, ok);
        for (int n = 0; n < N; n++) begin
            checks++;
            if (!ok || r[n] !== e1[n]) begin
                errors++;
                $display("FAIL transpose_ones[%0d]: got %0d, required %0d", n, r[n], e1[n]);
            end
        end
        @(negedge clk);
        run_txn(g2, r, lat, ok);
        for (int n = 0; n < N; n++) begin
            checks++;
            if (!ok || r[n] !== e2[n]) begin
                errors++;
                $display("FAIL transpose_last_row[%0d]: got %0d, required %0d", n, r[n], e2[n]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_signed_wrap();
        gvec_t g1 = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
        gvec_t g2 = '{-16'sd1, 16'sd2, -16'sd3, 16'sd4};
        ovec_t e2 = '{-32'sd1, 32'sd2, -32'sd3, 32'sd4};
        ovec_t r;
        int    lat;
        bit    ok;
        set_weight_const(-16'sd32768);
        run_txn(g1, r, lat, ok);
        for (int n = 0; n < N; n++) begin
            checks++;
            if (!ok || r[n] !== 32'sd131072) begin
                errors++;
                $display("FAIL signed_wrap[%0d]: got %0d, required 131072", n, r[n]);
            end
        end
        @(negedge clk);
        set_identity();
        run_txn(g2, r, lat, ok);
        for (int n = 0; n < N; n++) begin
            checks++;
            if (!ok || r[n] !== e2[n]) begin
                errors++;
                $display("FAIL signed_mixed[%0d]: got %0d, required %0d", n, r[n], e2[n]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        gvec_t g  = '{16'sd5, 16'sd6, 16'sd7, 16'sd8};
        gvec_t gp = '{16'sd9, 16'sd9, 16'sd9, 16'sd9};
        gvec_t gn = '{-16'sd2, -16'sd4, 16'sd6, 16'sd8};
        ovec_t e  = '{32'sd5, 32'sd6, 32'sd7, 32'sd8};
        ovec_t en = '{-32'sd2, -32'sd4, 32'sd6, 32'sd8};
        ovec_t r;
        int    lat;
        int    n_wait;
        bit    ok;
        set_identity();
        out_ready = 1'b0;
        run_txn(g, r, lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_first_result: out_valid=%b, required 1", out_valid);
        end
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin
                in_valid = 1'b1;
                grad_vec = gp;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vec !== e) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b out_vec=%0d,%0d,%0d,%0d, required 1 0 5,6,7,8",
                         c, out_valid, in_ready, out_vec[0], out_vec[1], out_vec[2], out_vec[3]);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        grad_vec  = gn;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_vec !== e) begin
            errors++;
            $display("FAIL bp_idle_gap: in_ready=%b busy=%b out_vec[0]=%0d, required 1 0 5",
                     in_ready, busy, out_vec[0]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: busy=%b, required 1", busy);
        end
        n_wait = 0;
        while (!out_valid && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        for (int n = 0; n < N; n++) begin
            checks++;
            if (out_valid !== 1'b1 || out_vec[n] !== en[n]) begin
                errors++;
                $display("FAIL bp_next_result[%0d]: got %0d (valid=%b), required %0d",
                         n, out_vec[n], out_valid, en[n]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        gvec_t g7 = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
        gvec_t g  = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        ovec_t e  = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
        ovec_t r;
        int    lat;
        bit    ok;
        set_identity();
        out_ready = 1'b1;
        grad_vec  = g7;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                     out_valid, in_ready, busy);
        end
        for (int n = 0; n < N; n++) begin
            checks++;
            if (out_vec[n] !== 32'sd0) begin
                errors++;
                $display("FAIL midrst_out_vec[%0d]: got %0d, required 0", n, out_vec[n]);
            end
        end
        run_txn(g, r, lat, ok);
        checks++;
        if (!ok || lat != 5 || r !== e) begin
            errors++;
            $display("FAIL midrst_fresh: ok=%0d lat=%0d out=%0d,%0d,%0d,%0d, required lat=5 out=1,2,3,4",
                     ok, lat, r[0], r[1], r[2], r[3]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        gvec_t g [3];
        logic [AW-1:0] exp_q [$];
        int    acc_cyc [3];
        int    na = 0;
        int    nr = 0;
        int    cyc = 0;
        bit    accepted;
        logic [AW-1:0] exp_v;
        g[0] = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        g[1] = '{16'sd0, 16'sd0, 16'sd0, 16'sd2};
        g[2] = '{16'sd3, -16'sd1, 16'sd0, 16'sd2};
        exp_q = '{32'd24, 32'd28, 32'd32, 32'd36,
                  32'd24, 32'd26, 32'd28, 32'd30,
                  32'd20, 32'd24, 32'd28, 32'd32};
        set_weight_ramp();
        out_ready = 1'b1;
        grad_vec  = g[0];
        in_valid  = 1'b1;
        while (nr < 3 && cyc < 100) begin
            accepted = in_valid && in_ready;
            if (accepted) begin
                acc_cyc[na] = cyc;
                na++;
            end
            if (out_valid) begin
                for (int n = 0; n < N; n++) begin
                    exp_v = exp_q.pop_front();
                    checks++;
                    if (out_vec[n] !== exp_v) begin
                        errors++;
                        $display("FAIL b2b_result %0d[%0d]: got %0d, required %0d",
                                 nr, n, out_vec[n], $signed(exp_v));
                    end
                end
                nr++;
            end
            @(negedge clk);
            cyc++;
            if (accepted) begin
                if (na < 3) grad_vec = g[na];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nr != 3 || na != 3) begin
            errors++;
            $display("FAIL b2b_count: results=%0d accepts=%0d, required 3 3", nr, na);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (i < na && acc_cyc[i] - acc_cyc[i-1] != M + 2) begin
                errors++;
                $display("FAIL b2b_spacing %0d: got %0d cycles, required %0d",
                         i, acc_cyc[i] - acc_cyc[i-1], M + 2);
            end
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < M; i++) grad_vec[i] = '0;
        set_identity();
        @(negedge clk);
        test_reset();
        test_identity();
        test_transpose();
        test_signed_wrap();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fcn_matrix_mult_transpose.md
Name: fcn_matrix_mult_transpose

Overview:
Sequential transpose matrix-vector unit for the backward (gradient) pass of the fully connected layer. It computes out_vec[n] = sum over m = 0..M-1 of (grad_vec[m] * weight[m][n]), which is the input gradient W^T * g. It shares the weight array layout [M][N] with the forward FC block, so one weight store can feed both. It processes one weight row per cycle, so N MACs run in parallel, and exchanges data through valid/ready handshakes on both sides.

Parameters:
M, 4, number of forward outputs; gradient vector length and weight rows
N, 4, number of forward inputs; result vector length and weight columns
DATA_WIDTH, 16, signed width of grad_vec and weight elements
ACC_WIDTH, 32, signed width of accumulators and out_vec elements

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  grad_vec is valid
in_ready  output  1  block can accept a new grad_vec
grad_vec  input  signed [DATA_WIDTH-1:0] x [M]  upstream gradient, captured on accept
weight  input  signed [DATA_WIDTH-1:0] x [M][N]  weight matrix, same indexing as the forward FC block
out_valid  output  1  out_vec holds a completed result
out_ready  input  1  consumer accepts out_vec
out_vec  output  signed [ACC_WIDTH-1:0] x [N]  input-gradient result
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (rst=1 at an edge), from any state: state=IDLE, row index=0, all accumulators and out_vec=0, grad register=0, out_valid=0, busy=0. in_ready=1 from the first cycle after reset. Reset in the middle of an operation discards the transaction; no partial result is emitted.
- FSM states are IDLE, ACCUM and DONE. in_ready = (state==IDLE), out_valid = (state==DONE) and busy = !IDLE. All three are decoded combinationally from the registered state.
- IDLE: if in_valid is high, capture grad_vec into the grad register, clear all N accumulators, set idx=0 and go to ACCUM. Otherwise stay in IDLE.
- ACCUM, one cycle per row: for every n, acc[n] += grad_r[idx] * weight[idx][n].
  - Each product is a full 2*DATA_WIDTH signed product, sign-extended or truncated to ACC_WIDTH.
  - The sum wraps in two's complement modulo 2^ACC_WIDTH. There is no saturation, matching the forward block.
  - If idx==M-1, go to DONE. Otherwise idx++.
  - For M=1 the block spends exactly one cycle in ACCUM.
- The idx counter width is max(1, $clog2(M)).
- DONE: out_vec is driven from the accumulator registers and stays stable. If out_ready is high, go to IDLE; otherwise hold.
- Latency: accept in cycle T; ACCUM occupies cycles T+1..T+M; out_valid is high from cycle T+M+1.
- Throughput: with out_ready tied high, one transaction every M+2 cycles. There is always one IDLE cycle between DONE and the next accept, and no overlap of transactions.
- Stability requirements:
  - weight must stay stable from the accept cycle until out_valid. Row idx is sampled in each ACCUM cycle.
  - grad_vec may change freely after accept.
- Backpressure: while out_valid=1 and out_ready=0, out_vec, out_valid and in_ready=0 are held. in_valid is ignored.
- Simultaneous events:
  - rst has priority over any handshake.
  - in_valid outside IDLE has no effect.
- out_vec keeps the last result after it is consumed, until the next accept clears the accumulators.

Test Plan:
1. Identity weight, grad=[1,2,3,4], out_ready=1 -> out_vec=[1,2,3,4]; out_valid rises exactly 5 cycles after the accept cycle and lasts 1 cycle.
2. Transpose check: weight[m][n]=4m+n, grad=[1,1,1,1] -> out_vec=[24,28,32,36]. Same weight with grad=[0,0,0,2] -> [24,26,28,30].
3. Signed wrap: all weight=-32768, all grad=32767 -> each out_vec element = 131072 (the true value -4294836224 wrapped mod 2^32). Then grad=[-1,2,-3,4] with identity weight -> [-1,2,-3,4].
4. Backpressure: hold out_ready=0 for 6 cycles after out_valid, and pulse in_valid with a new grad -> out_vec unchanged, in_ready=0, new grad not captured. After release the result is consumed, with 1 IDLE cycle before the next accept.
5. Reset mid-op: assert rst in the 2nd ACCUM cycle -> next cycle out_valid=0, in_ready=1, out_vec=[0,0,0,0]. A fresh transaction (test 1 stimulus) gives [1,2,3,4].
6. Back-to-back streaming: in_valid and out_ready held high, 3 distinct grads -> 3 correct results, accepts spaced exactly M+2=6 cycles apart.
